// File: rtl/sig_pkg.sv
// Shared types for the sig_gen/sig_rcv serial link receiver.
package sig_pkg;

  // Reason a received frame was rejected.
  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_SHORT  = 2'd1,
    ERR_LONG   = 2'd2,
    ERR_GLITCH = 2'd3
  } err_code_t;

  // Receiver sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } rx_state_t;

endpackage

// File: rtl/sig_rcv_if.sv
// Link-side and result-side signals of the serial receiver, bundled.
interface sig_rcv_if #(
  parameter int unsigned MESSAGE_WIDTH = 8
);

  logic                     data_in;
  logic                     valid_in;
  logic [MESSAGE_WIDTH-1:0] msg_out;
  logic                     msg_valid_out;
  logic                     err_out;
  logic [1:0]               err_code_out;
  logic                     busy_out;

  // Driver of the wire and consumer of the results.
  modport master (
    output data_in,
    output valid_in,
    input  msg_out,
    input  msg_valid_out,
    input  err_out,
    input  err_code_out,
    input  busy_out
  );

  // The receiver itself.
  modport slave (
    input  data_in,
    input  valid_in,
    output msg_out,
    output msg_valid_out,
    output err_out,
    output err_code_out,
    output busy_out
  );

endinterface

// File: rtl/sig_rcv.sv
// Serial frame receiver: deserializes MSB-first frames where every bit is held
// CYCLES_PER_BIT clocks, validates length and per-bit stability, and reports
// either a one-cycle word-valid pulse or a one-cycle error pulse.
module sig_rcv
  import sig_pkg::*;
#(
  parameter int unsigned MESSAGE_WIDTH  = 8,
  parameter int unsigned CYCLES_PER_BIT = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     data_in,
  input  logic                     valid_in,
  output logic [MESSAGE_WIDTH-1:0] msg_out,
  output logic                     msg_valid_out,
  output logic                     err_out,
  output logic [1:0]               err_code_out,
  output logic                     busy_out
);

  localparam int unsigned CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int unsigned BW = (MESSAGE_WIDTH > 1) ? $clog2(MESSAGE_WIDTH) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CYCLES_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(MESSAGE_WIDTH - 1);

  rx_state_t                state_q, state_d;
  logic                     valid_prev_q;
  logic                     ref_bit_q;
  logic                     glitch_q;
  logic [CW-1:0]            cyc_q;
  logic [BW-1:0]            bit_q;
  logic [MESSAGE_WIDTH-1:0] shreg_q;

  logic start_c;
  logic cyc_last_c;
  logic bit_last_c;

  assign start_c    = valid_in && !valid_prev_q;
  assign cyc_last_c = (cyc_q == CYC_LAST);
  assign bit_last_c = (bit_q == BIT_LAST);
  assign busy_out   = (state_q != IDLE);

  // Next-state selection; errors and completion always return to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_c) state_d = RECV;
      RECV: begin
        if (!valid_in)                      state_d = IDLE;
        else if (cyc_last_c && bit_last_c)  state_d = CHECK;
      end
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Edge detect, bit timing, shift register, stability check and result pulses.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      valid_prev_q  <= 1'b1;  // ignore a frame already in flight at reset
      ref_bit_q     <= 1'b0;
      glitch_q      <= 1'b0;
      cyc_q         <= '0;
      bit_q         <= '0;
      shreg_q       <= '0;
      msg_out       <= '0;
      msg_valid_out <= 1'b0;
      err_out       <= 1'b0;
      err_code_out  <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      valid_prev_q  <= valid_in;
      msg_valid_out <= 1'b0;
      err_out       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_c) begin
            ref_bit_q <= data_in;
            cyc_q     <= CW'(1);
            bit_q     <= '0;
            glitch_q  <= 1'b0;
          end
        end
        RECV: begin
          if (!valid_in) begin
            err_out      <= 1'b1;
            err_code_out <= ERR_SHORT;
          end else begin
            if (cyc_q == '0)             ref_bit_q <= data_in;
            else if (data_in != ref_bit_q) glitch_q <= 1'b1;
            if (cyc_last_c) begin
              shreg_q <= MESSAGE_WIDTH'({shreg_q, data_in});
              cyc_q   <= '0;
              if (!bit_last_c) bit_q <= bit_q + BW'(1);
            end else begin
              cyc_q <= cyc_q + CW'(1);
            end
          end
        end
        CHECK: begin
          if (valid_in) begin
            err_out      <= 1'b1;
            err_code_out <= ERR_LONG;
          end else if (glitch_q) begin
            err_out      <= 1'b1;
            err_code_out <= ERR_GLITCH;
          end else begin
            msg_out       <= shreg_q;
            msg_valid_out <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
